uart_tx_fifo_ctrl: RTL and testbench

//  Drains the transmit byte FIFO and serialises each byte onto the UART tx line.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_counter.sv | 28 ++
 rtl/uart_tx_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: FSM states, frame sizing, parity.
// Pure declarations; no timing behaviour of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int START_BITS     = 1;
    localparam int MAX_DATA_WIDTH = 64;

    // Bits on the line for one character, start bit included.
    function automatic int frame_bits(input int data_width, input int parity_en, input int stop_bits);
        return START_BITS + data_width + parity_en + stop_bits;
    endfunction

    function automatic int frame_cycles(input int data_width, input int parity_en,
                                        input int stop_bits, input int clks_per_bit);
        return frame_bits(data_width, parity_en, stop_bits) * clks_per_bit;
    endfunction

    // Zero extension of narrower data leaves the reduction unchanged.
    function automatic logic parity_of(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: tick is high in the final cycle of every CLKS_PER_BIT-cycle period.
// Zero latency from reload; held at zero while reload is asserted, no backpressure.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic reload,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (reload || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Pops the tx FIFO and serialises each byte as start, data LSB first, optional parity, stop bit(s).
// Start bit one cycle after the pop; only pops when idle or in the last stop cycle, so frames abut.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    uart_state_t            state_q;
    uart_state_t            state_d;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   parity_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   stop_cnt_q;
    logic                   tick;
    logic                   last_data;
    logic                   last_stop;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .reload(state_q == IDLE),
        .tick  (tick)
    );

    assign last_data = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1));
    assign last_stop = (state_q == STOP) && tick && (stop_cnt_q == 1'(STOP_BITS - 1));

    // Reset gates the strobe so nothing is popped while the frame logic is held.
    assign fifo_read = reset && enable && !fifo_empty && ((state_q == IDLE) || last_stop);
    assign tx_done   = last_stop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_read) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && last_data) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (last_stop) state_d = fifo_read ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            PARITY:  tx = parity_q;
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);

            if (fifo_read) begin
                shift_q  <= fifo_data;
                parity_q <= parity_of(MAX_DATA_WIDTH'(fifo_data), (PARITY_ODD != 0));
            end else if ((state_q == DATA) && tick) begin
                shift_q <= shift_q >> 1;
            end

            if (state_q != DATA) begin
                bit_cnt_q <= '0;
            end else if (tick) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end

            if (state_q != STOP) begin
                stop_cnt_q <= 1'b0;
            end else if (tick) begin
                stop_cnt_q <= stop_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: a plain instance plus even- and odd-parity instances sharing one FIFO model.
module tb_uart_tx_fifo_ctrl;

    localparam int CPB = 4;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read, tx, busy, tx_done;
    logic       rd_e, tx_e, busy_e, done_e;
    logic       rd_o, tx_o, busy_o, done_o;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    int         pops         = 0;
    int         underflows   = 0;
    int         last_pop_cyc = -1;
    logic [7:0] q[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read(fifo_read), .tx(tx), .busy(busy), .tx_done(tx_done));

    uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read(rd_e), .tx(tx_e), .busy(busy_e), .tx_done(done_e));

    uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read(rd_o), .tx(tx_o), .busy(busy_o), .tx_done(done_o));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        exp_q.push_back(b);
        refresh();
    endtask

    // One clock: the FIFO model follows the main instance's pop strobe.
    task automatic cycle();
        logic       rd;
        logic [7:0] popped;
        #1;
        rd = fifo_read;
        if (rd && fifo_empty) underflows++;
        @(posedge clock);
        if (rd) last_pop_cyc = cyc;
        cyc++;
        #1;
        if (rd && q.size() != 0) begin
            popped = q.pop_front();
            pops++;
            refresh();
        end
        @(negedge clock);
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 1) ? tx_e : (sel == 2) ? tx_o : tx;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 1) ? done_e : (sel == 2) ? done_o : tx_done;
    endfunction

    // Waits for a start bit, then records one full frame; leaves the bench in its last cycle.
    task automatic recv(input int sel, input int drop_at, output logic [15:0] bits, output int start_cyc,
                        output int waited, output int glitches, output int done_pos, output int done_cnt);
        int   nbits;
        logic s;
        nbits     = (sel == 0) ? 10 : 11;
        bits      = '0;
        waited    = 0;
        glitches  = 0;
        done_pos  = -1;
        done_cnt  = 0;
        start_cyc = -1;
        while (tx_of(sel) !== 1'b0 && waited < 400) begin
            cycle();
            waited++;
        end
        if (tx_of(sel) === 1'b0) begin
            start_cyc = cyc;
            for (int i = 0; i < nbits * CPB; i++) begin
                if (i == drop_at) enable = 1'b0;
                s = tx_of(sel);
                if (i % CPB == 0) bits[i / CPB] = s;
                else if (s !== bits[i / CPB]) glitches++;
                if (done_of(sel) === 1'b1) begin
                    done_cnt++;
                    done_pos = i;
                end
                if (i != nbits * CPB - 1) cycle();
            end
        end
    endtask

    task automatic test_reset();
        int viol;
        reset  = 1'b0;
        enable = 1'b1;
        q.delete();
        refresh();
        cycle();
        q.push_back(8'h3C);
        refresh();
        #1;
        tests_run++;
        if (fifo_read !== 1'b0 || rd_e !== 1'b0 || rd_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fifo_read: got %b%b%b want 000", fifo_read, rd_e, rd_o);
        end
        tests_run++;
        if (tx !== 1'b1 || tx_e !== 1'b1 || tx_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_tx: got %b%b%b want 111", tx, tx_e, tx_o);
        end
        tests_run++;
        if (busy !== 1'b0 || busy_e !== 1'b0 || busy_o !== 1'b0 || tx_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy_done: got busy %b%b%b done %b want 000 0", busy, busy_e, busy_o, tx_done);
        end
        q.delete();
        refresh();
        @(negedge clock);
        reset = 1'b1;
        viol  = 0;
        repeat (100) begin
            cycle();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0 || tx_done !== 1'b0 ||
                rd_e !== 1'b0 || rd_o !== 1'b0) viol++;
        end
        tests_run++;
        if (viol != 0 || pops != 0) begin
            tests_failed++;
            $display("FAIL idle_empty: got %0d violations %0d pops want 0 0", viol, pops);
        end
    endtask

    task automatic test_parity();
        logic [15:0] bits;
        logic [7:0]  b;
        logic        par;
        int          st, w, gl, dp, dc, ones;
        for (int pass = 0; pass < 2; pass++) begin
            push(8'h07);
            recv(pass + 1, -1, bits, st, w, gl, dp, dc);
            b    = exp_q.pop_front();
            ones = $countones(b);
            par  = (pass == 0) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            tests_run++;
            if (st < 0 || bits[10:0] !== {1'b1, par, b, 1'b0} || gl != 0) begin
                tests_failed++;
                $display("FAIL parity_frame_%0d: got bits %b glitches %0d want %b 0",
                         pass, bits[10:0], gl, {1'b1, par, b, 1'b0});
            end
            tests_run++;
            if (dp != 4 * 11 - 1 || dc != 1) begin
                tests_failed++;
                $display("FAIL parity_len_%0d: got done at %0d x%0d want %0d x1", pass, dp, dc, 4 * 11 - 1);
            end
            repeat (2) cycle();
        end
    endtask

    task automatic test_single();
        logic [15:0] bits;
        logic [7:0]  b;
        int          st, w, gl, dp, dc, p0;
        p0 = pops;
        push(8'hA5);
        recv(0, -1, bits, st, w, gl, dp, dc);
        b = exp_q.pop_front();
        tests_run++;
        if (st < 0 || bits[9:0] !== {1'b1, b, 1'b0} || gl != 0) begin
            tests_failed++;
            $display("FAIL single_frame: got bits %b glitches %0d want %b 0", bits[9:0], gl, {1'b1, b, 1'b0});
        end
        tests_run++;
        if (st != last_pop_cyc + 1 || pops - p0 != 1) begin
            tests_failed++;
            $display("FAIL single_latency: got start %0d pop %0d pops %0d want start=pop+1 pops 1",
                     st, last_pop_cyc, pops - p0);
        end
        tests_run++;
        if (dp != 39 || dc != 1) begin
            tests_failed++;
            $display("FAIL single_done: got done at %0d x%0d want 39 x1", dp, dc);
        end
        cycle();
        tests_run++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_idle: got busy %b tx %b want 0 1", busy, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits1, bits2;
        logic [7:0]  b1, b2;
        int          st1, st2, w1, w2, gl1, gl2, dp1, dp2, dc1, dc2, pop2;
        push(8'h01);
        push(8'h80);
        recv(0, -1, bits1, st1, w1, gl1, dp1, dc1);
        recv(0, -1, bits2, st2, w2, gl2, dp2, dc2);
        pop2 = last_pop_cyc;
        b1   = exp_q.pop_front();
        b2   = exp_q.pop_front();
        tests_run++;
        if (bits1[9:0] !== {1'b1, b1, 1'b0} || bits2[9:0] !== {1'b1, b2, 1'b0} || gl1 + gl2 != 0) begin
            tests_failed++;
            $display("FAIL b2b_frames: got %b %b want %b %b", bits1[9:0], bits2[9:0],
                     {1'b1, b1, 1'b0}, {1'b1, b2, 1'b0});
        end
        tests_run++;
        if (w2 != 1 || st2 != st1 + 40 || pop2 != st1 + 39) begin
            tests_failed++;
            $display("FAIL b2b_gap: got wait %0d start2-start1 %0d pop2-start1 %0d want 1 40 39",
                     w2, st2 - st1, pop2 - st1);
        end
        tests_run++;
        if (dc1 != 1 || dc2 != 1 || dp2 != 39) begin
            tests_failed++;
            $display("FAIL b2b_done: got %0d %0d at %0d want 1 1 at 39", dc1, dc2, dp2);
        end
        cycle();
    endtask

    task automatic test_enable_drop();
        logic [15:0] bits;
        logic [7:0]  b;
        int          st, w, gl, dp, dc, viol;
        enable = 1'b1;
        push(8'h5A);
        push(8'hC3);
        push(8'h3E);
        recv(0, 9, bits, st, w, gl, dp, dc);
        b = exp_q.pop_front();
        tests_run++;
        if (st < 0 || bits[9:0] !== {1'b1, b, 1'b0} || gl != 0 || dp != 39 || dc != 1) begin
            tests_failed++;
            $display("FAIL enable_drop_frame: got %b done %0d x%0d want %b done 39 x1",
                     bits[9:0], dp, dc, {1'b1, b, 1'b0});
        end
        viol = 0;
        repeat (20) begin
            cycle();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) viol++;
        end
        tests_run++;
        if (viol != 0 || q.size() != 2) begin
            tests_failed++;
            $display("FAIL enable_drop_hold: got %0d violations fifo %0d want 0 2", viol, q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] bits;
        logic [7:0]  b;
        int          st, w, gl, dp, dc, n;
        enable = 1'b1;
        n      = 0;
        while (tx !== 1'b0 && n < 20) begin
            cycle();
            n++;
        end
        repeat (16) cycle();
        reset = 1'b0;
        #1;
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || fifo_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got tx %b busy %b done %b rd %b want 1 0 0 0",
                     tx, busy, tx_done, fifo_read);
        end
        b = exp_q.pop_front();
        repeat (3) cycle();
        tests_run++;
        if (q.size() != 1 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_hold: got fifo %0d tx %b want 1 1", q.size(), tx);
        end
        reset = 1'b1;
        recv(0, -1, bits, st, w, gl, dp, dc);
        b = exp_q.pop_front();
        tests_run++;
        if (st < 0 || bits[9:0] !== {1'b1, b, 1'b0} || gl != 0 || dc != 1 || dp != 39) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got %b done %0d x%0d want %b done 39 x1",
                     bits[9:0], dp, dc, {1'b1, b, 1'b0});
        end
        repeat (2) cycle();
        tests_run++;
        if (q.size() != 0 || underflows != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL final_state: got fifo %0d underflows %0d busy %b want 0 0 0",
                     q.size(), underflows, busy);
        end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        refresh();
        @(negedge clock);
        test_reset();
        test_parity();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
